// File: rtl/pwm_gen_multi.sv
// Multi-channel PWM generator: one shared period counter, shadowed per-channel
// duty thresholds, optional phase interleave and per-channel output inversion.
//   clk, rst            : clock, synchronous active-high reset
//   en                  : global enable (idle outputs sit at inv level)
//   phase_en            : stagger channel k by k*(PERIOD/CHANNELS) clocks
//   duty_cycle[8k+:8]   : channel k duty in percent, >100 clamps to 100
//   inv[k]              : invert channel k
//   pwm_out[k]          : registered PWM outputs
//   period_tick         : one-clock pulse marking the end of each period
module pwm_gen_multi #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int PWM_FREQ = 1000,
    parameter int CHANNELS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    phase_en,
    input  logic [8*CHANNELS-1:0]   duty_cycle,
    input  logic [CHANNELS-1:0]     inv,
    output logic [CHANNELS-1:0]     pwm_out,
    output logic                    period_tick
);

    localparam int PERIOD = CLK_FREQ / PWM_FREQ;
    localparam int CW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    // thresholds must hold PERIOD itself (duty 100)
    localparam int TW     = $clog2(PERIOD + 1);
    // local count before wrap can reach 2*PERIOD-2
    localparam int LW     = TW + 1;
    localparam int MW     = $clog2(100 * PERIOD + 1);
    localparam int STEP   = PERIOD / CHANNELS;
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    generate
        if (PERIOD < CHANNELS || PERIOD < 2 || CHANNELS < 1 || CHANNELS > 16) begin : g_bad_cfg
            $error("pwm_gen_multi: PERIOD must be >= 2 and >= CHANNELS, CHANNELS 1..16");
        end
    endgenerate

    logic [CW-1:0] r_cnt;
    // the shadowed duty is kept directly in period units
    logic [TW-1:0] r_thr [CHANNELS];
    logic          r_ph;

    logic          w_last;
    logic          w_load;
    logic [6:0]    w_dcl   [CHANNELS];
    logic [MW-1:0] w_prod  [CHANNELS];
    logic [TW-1:0] w_thr_nx[CHANNELS];
    logic [LW-1:0] w_sum   [CHANNELS];
    logic [LW-1:0] w_lc    [CHANNELS];
    logic [CHANNELS-1:0] w_act;

    always_comb begin
        w_last = (r_cnt == LAST);
        // while disabled the shadows track the inputs so a restart is fresh
        w_load = !en || w_last;
        w_act  = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            w_dcl[k]    = (duty_cycle[8*k +: 8] > 8'd100) ? 7'd100 : duty_cycle[8*k +: 7];
            w_prod[k]   = MW'(w_dcl[k]) * MW'(PERIOD);
            w_thr_nx[k] = TW'(w_prod[k] / MW'(100));
            w_sum[k]    = LW'(r_cnt) + LW'(k * STEP);
            // offset < PERIOD, so a single conditional subtract is the modulo
            w_lc[k]     = (w_sum[k] >= LW'(PERIOD)) ? (w_sum[k] - LW'(PERIOD)) : w_sum[k];
            if (!r_ph) begin
                w_lc[k] = LW'(r_cnt);
            end
            w_act[k]    = (w_lc[k] < LW'(r_thr[k]));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_ph        <= 1'b0;
            pwm_out     <= '0;
            period_tick <= 1'b0;
            for (int k = 0; k < CHANNELS; k++) begin
                r_thr[k] <= '0;
            end
        end else begin
            if (!en) begin
                r_cnt       <= '0;
                period_tick <= 1'b0;
            end else begin
                r_cnt       <= w_last ? '0 : (r_cnt + CW'(1));
                period_tick <= w_last;
            end
            if (w_load) begin
                r_ph <= phase_en;
                for (int k = 0; k < CHANNELS; k++) begin
                    r_thr[k] <= w_thr_nx[k];
                end
            end
            pwm_out <= ({CHANNELS{en}} & w_act) ^ inv;
        end
    end

endmodule

// File: tb/tb_pwm_gen_multi.sv
// Directed bench for pwm_gen_multi with PERIOD=100, CHANNELS=4:
// table of per-period vectors plus reset, mid-period and enable sequences.
module tb_pwm_gen_multi;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        phase_en;
    logic [31:0] duty_cycle;
    logic [3:0]  inv;
    logic [3:0]  pwm_out;
    logic        period_tick;

    int n_tests = 0;
    int n_fail  = 0;

    pwm_gen_multi #(
        .CLK_FREQ(1000),
        .PWM_FREQ(10),
        .CHANNELS(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .phase_en(phase_en),
        .duty_cycle(duty_cycle),
        .inv(inv),
        .pwm_out(pwm_out),
        .period_tick(period_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] duty;
        logic [3:0]  inv;
        logic        ph;
        int          hi[4];
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // expected level of channel k at counter value c (PERIOD=100, step 25)
    function automatic logic model(input int k, input int c, input logic [7:0] d,
                                   input logic ph, input logic iv);
        int thr;
        int lc;
        thr = (d > 100) ? 100 : int'(d);
        lc  = ph ? ((c + k * 25) % 100) : c;
        return logic'(lc < thr) ^ iv;
    endfunction

    // cycles until period_tick is seen, -1 on timeout
    task automatic wait_tick(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (period_tick) begin
                cyc = i;
                break;
            end
        end
    endtask

    // one full period, sample i shows the output for cnt=i
    task automatic window(input logic [31:0] d, input logic [3:0] iv, input logic ph,
                          output int hi[4], output int bad[4], output int ticks);
        ticks = 0;
        for (int k = 0; k < 4; k++) begin
            hi[k]  = 0;
            bad[k] = 0;
        end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (period_tick) ticks++;
            for (int k = 0; k < 4; k++) begin
                if (pwm_out[k]) hi[k]++;
                if (pwm_out[k] !== model(k, i, d[8*k +: 8], ph, iv[k])) bad[k]++;
            end
        end
    endtask

    initial begin
        int cyc;
        int cnt;
        int hi[4];
        int bad[4];
        int ticks;

        vecs[0] = '{32'h19191919, 4'b0000, 1'b0, '{25, 25, 25, 25}};
        vecs[1] = '{32'h32323232, 4'b0000, 1'b1, '{50, 50, 50, 50}};
        vecs[2] = '{32'h646E6400, 4'b0000, 1'b0, '{0, 100, 100, 100}};
        vecs[3] = '{32'h19191919, 4'b0001, 1'b0, '{75, 25, 25, 25}};
        vecs[4] = '{32'h6343210A, 4'b0000, 1'b1, '{10, 33, 67, 99}};

        rst        = 1'b1;
        en         = 1'b1;
        phase_en   = 1'b0;
        duty_cycle = 32'h19191919;
        inv        = 4'b1111;
        repeat (5) @(negedge clk);
        chk("reset pwm_out", int'(pwm_out), 0);
        chk("reset tick", int'(period_tick), 0);

        rst = 1'b0;
        inv = 4'b0000;
        cyc = -1;
        cnt = 0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (period_tick) begin
                cyc = i;
                break;
            end
            if (|pwm_out) cnt++;
        end
        chk("first tick latency", cyc, 100);
        chk("post-reset shadow zero", cnt, 0);

        for (int v = 0; v < 5; v++) begin
            duty_cycle = vecs[v].duty;
            inv        = vecs[v].inv;
            phase_en   = vecs[v].ph;
            wait_tick(cyc);
            chk($sformatf("v%0d tick wait", v), int'(cyc > 0), 1);
            window(vecs[v].duty, vecs[v].inv, vecs[v].ph, hi, bad, ticks);
            chk($sformatf("v%0d ticks", v), ticks, 1);
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("v%0d ch%0d high", v, k), hi[k], vecs[v].hi[k]);
                chk($sformatf("v%0d ch%0d shape", v, k), bad[k], 0);
            end
        end

        // duty change mid-period waits for the boundary
        duty_cycle = 32'h19191919;
        inv        = 4'b0000;
        phase_en   = 1'b0;
        wait_tick(cyc);
        chk("mid tick wait", int'(cyc > 0), 1);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i == 40) duty_cycle[7:0] = 8'd75;
            if (pwm_out[0]) cnt++;
        end
        chk("mid change old period", cnt, 25);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (pwm_out[0]) cnt++;
        end
        chk("mid change new period", cnt, 75);

        // disabled: idle at inv level, inv unshadowed
        inv = 4'b0001;
        en  = 1'b0;
        @(negedge clk);
        chk("disabled pwm_out", int'(pwm_out), 1);
        chk("disabled tick", int'(period_tick), 0);
        inv = 4'b0110;
        @(negedge clk);
        chk("disabled inv change", int'(pwm_out), 6);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (period_tick) cnt++;
        end
        chk("disabled no ticks", cnt, 0);
        duty_cycle = 32'h00000032;
        inv        = 4'b0000;
        @(negedge clk);
        en = 1'b1;
        window(32'h00000032, 4'b0000, 1'b0, hi, bad, ticks);
        chk("restart ch0 high", hi[0], 50);
        chk("restart ch0 shape", bad[0], 0);
        chk("restart ch1 high", hi[1], 0);
        chk("restart ticks", ticks, 1);

        // reset mid-period with outputs high
        duty_cycle = 32'h64646464;
        wait_tick(cyc);
        chk("rst tick wait", int'(cyc > 0), 1);
        repeat (60) @(negedge clk);
        chk("pre-reset high", int'(pwm_out), 15);
        rst = 1'b1;
        @(negedge clk);
        chk("mid reset pwm_out", int'(pwm_out), 0);
        chk("mid reset tick", int'(period_tick), 0);
        @(negedge clk);
        rst = 1'b0;
        cyc = -1;
        cnt = 0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (period_tick) begin
                cyc = i;
                break;
            end
            if (|pwm_out) cnt++;
        end
        chk("restart tick latency", cyc, 100);
        chk("restart shadow zero", cnt, 0);
        @(negedge clk);
        chk("after boundary full", int'(pwm_out), 15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
